// File: rtl/cpu_clock_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_clock_sequencer
//
// Generates the CPU pipeline advance strobe from the board clock. The pipeline
// stays on clockIn and advances only on cycles where cpuEn is high. The
// supported modes are halt, free-run at a divided rate, single-step from a
// debounced push button, and a burst of N steps.
//
// Ports:
//   clockIn     in   1            board clock, the only clock
//   resetN      in   1            asynchronous active-low reset
//   modeSel     in   2            00 halt, 01 run, 10 single step, 11 burst
//   stepBtn     in   1            raw asynchronous push button, active-high
//   burstCount  in   BURST_WIDTH  burst length, sampled when a burst starts
//   cpuEn       out  1            one-cycle pipeline advance strobe (registered)
//   cpuClock    out  1            visible square wave for the LED
//   busy        out  1            high while running or bursting
//   stepCount   out  16           total cpuEn pulses issued, wraps
// -----------------------------------------------------------------------------
module cpu_clock_sequencer #(
    parameter int DIV_WIDTH       = 25,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BURST_WIDTH     = 8
) (
    input  logic                   clockIn,
    input  logic                   resetN,
    input  logic [1:0]             modeSel,
    input  logic                   stepBtn,
    input  logic [BURST_WIDTH-1:0] burstCount,
    output logic                   cpuEn,
    output logic                   cpuClock,
    output logic                   busy,
    output logic [15:0]            stepCount
);

    // Mode encodings; 2'b00 (halt) is simply "none of the others".
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int DEB_WIDTH = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_WIDTH-1:0] DEB_LAST = DEB_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } SeqState;

    SeqState                state;
    SeqState                nextState;

    logic                   btnMeta;
    logic                   btnSync;
    logic [DEB_WIDTH-1:0]   debCnt;
    logic                   btnStable;
    logic                   btnStableDly;
    logic                   stepReq;

    logic [DIV_WIDTH-1:0]   divCnt;
    logic                   tick;

    logic [BURST_WIDTH-1:0] remaining;
    logic [BURST_WIDTH-1:0] remainingNext;
    logic                   cpuEnNext;

    // -------------------------------------------------------------------------
    // Button path: two-flop synchronizer followed by a debounce counter. A new
    // level is accepted only after it has been seen for DEBOUNCE_CYCLES
    // consecutive cycles; any bounce back to the accepted level restarts it.
    // -------------------------------------------------------------------------
    // NOTE: clocked blocks use non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the
    // synchronizer into a single flop.
    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            btnMeta      <= 1'b0;
            btnSync      <= 1'b0;
            debCnt       <= '0;
            btnStable    <= 1'b0;
            btnStableDly <= 1'b0;
        end else begin
            btnMeta      <= stepBtn;
            btnSync      <= btnMeta;
            btnStableDly <= btnStable;
            if (btnSync != btnStable) begin
                if (debCnt == DEB_LAST) begin
                    btnStable <= btnSync;
                    debCnt    <= '0;
                end else begin
                    debCnt <= debCnt + DEB_WIDTH'(1);
                end
            end else begin
                debCnt <= '0;
            end
        end
    end

    // One-cycle request on the cycle the debounced level first reads high.
    assign stepReq = btnStable & ~btnStableDly;

    // -------------------------------------------------------------------------
    // Divider: free-running only while active, held at zero when idle so the
    // first tick after entering RUN/BURST lands a full period later.
    // -------------------------------------------------------------------------
    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            divCnt <= '0;
        end else if (state == IDLE) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + DIV_WIDTH'(1);
        end
    end

    assign tick = &divCnt;

    // -------------------------------------------------------------------------
    // Sequencer next-state and strobe decode.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState     = state;
        remainingNext = remaining;
        cpuEnNext     = 1'b0;

        case (state)
            IDLE: begin
                if (modeSel == MODE_RUN) begin
                    nextState = RUN;
                end else if (modeSel == MODE_STEP && stepReq) begin
                    cpuEnNext = 1'b1;
                end else if (modeSel == MODE_BURST && stepReq && burstCount != '0) begin
                    remainingNext = burstCount;
                    nextState     = BURST;
                end
            end

            RUN: begin
                // Leaving RUN wins over a coincident tick: no pulse on exit.
                if (modeSel != MODE_RUN) begin
                    nextState = IDLE;
                end else if (tick) begin
                    cpuEnNext = 1'b1;
                end
            end

            BURST: begin
                if (modeSel != MODE_BURST) begin
                    nextState     = IDLE;
                    remainingNext = '0;
                end else if (tick) begin
                    cpuEnNext     = 1'b1;
                    remainingNext = remaining - BURST_WIDTH'(1);
                    if (remaining == BURST_WIDTH'(1)) begin
                        nextState = IDLE;
                    end
                end
            end

            default: begin
                nextState     = IDLE;
                remainingNext = '0;
            end
        endcase
    end

    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            remaining <= '0;
            cpuEn     <= 1'b0;
            busy      <= 1'b0;
            stepCount <= '0;
        end else begin
            state     <= nextState;
            remaining <= remainingNext;
            cpuEn     <= cpuEnNext;
            busy      <= (nextState != IDLE);
            // Counts in step with the strobe, so it already includes the
            // pulse that is currently high.
            if (cpuEnNext) begin
                stepCount <= stepCount + 16'd1;
            end
        end
    end

    // LED square wave: divider MSB while active, dark while idle.
    assign cpuClock = (state != IDLE) && divCnt[DIV_WIDTH-1];

endmodule

// File: doc/cpu_clock_sequencer.md
# cpu_clock_sequencer

Generates the CPU pipeline's advance strobe from the board clock. It replaces a free-running divided clock with a single-clock-domain enable pulse `cpuEn`, so the pipeline registers stay on `clockIn` and advance only when `cpuEn` is high. Four modes are supported: halt, free-run at a divided rate, single-step from a debounced push button, and N-step burst. It sits between the board clock/button inputs and the pipeline register enables, and also drives the LED/debug outputs.

## Interface
- `DIV_WIDTH`, default 25: divider width; the run/burst pulse period is 2^DIV_WIDTH cycles.
- `DEBOUNCE_CYCLES`, default 1000000: number of consecutive stable cycles required to accept a button level.
- `BURST_WIDTH`, default 8: width of the burst length input and the remaining-step counter.

Ports:
- `clockIn`  in  1  board clock; the only clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `modeSel`  in  2  00 halt, 01 run, 10 single step, 11 burst.
- `stepBtn`  in  1  raw asynchronous push button, active-high.
- `burstCount`  in  BURST_WIDTH  burst length, sampled at burst start.
- `cpuEn`  out  1  one-cycle pipeline advance strobe, registered.
- `cpuClock`  out  1  visible square wave for the LED.
- `busy`  out  1  high while in RUN or BURST.
- `stepCount`  out  16  total `cpuEn` pulses issued, wraps.

## Operation
- **Button path:**
  - 2-flop synchronizer, then a debounce counter.
  - When the synchronized level differs from `btnStable`, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1, `btnStable` takes the new level and the counter clears.
  - A rising edge of `btnStable` produces a one-cycle internal `stepReq`.
- **Divider:**
  - `divCnt` (DIV_WIDTH bits) increments every cycle while the state is RUN or BURST, and is forced to 0 in IDLE.
  - `tick` = `divCnt` all-ones; the counter wraps to 0 after it.
- **FSM states:** IDLE, RUN, BURST.
  - IDLE, `modeSel`=01: go to RUN.
  - IDLE, `modeSel`=10, `stepReq`: stay in IDLE and issue one `cpuEn`.
  - IDLE, `modeSel`=11, `stepReq`, `burstCount`≠0: load `remaining`=`burstCount`, go to BURST.
  - IDLE, `modeSel`=11, `stepReq`, `burstCount`=0: ignored.
  - IDLE, `modeSel`=00: stay in IDLE.
  - RUN: `cpuEn` on every `tick`. Go to IDLE the cycle `modeSel`≠01 is seen. A tick in that same cycle is suppressed.
  - BURST, on `tick`: issue `cpuEn` and decrement `remaining`. When `remaining` was 1, go to IDLE after that pulse.
  - BURST, `modeSel`≠11: abort to IDLE immediately with no further pulses. `remaining` clears.
  - `stepReq` in RUN or BURST is ignored.
- `cpuClock` = `divCnt[DIV_WIDTH-1]` in RUN/BURST, 0 in IDLE.
- `busy` = (state ≠ IDLE), registered with the state.
- `stepCount` increments with every `cpuEn` pulse; 0xFFFF wraps to 0x0000.
- **Reset (async, `resetN` low):**
  - Cleared: state IDLE, `cpuEn`, `cpuClock`, `busy`, `stepCount`, `divCnt`, `remaining`, debounce counter, synchronizer flops, `btnStable`.
  - Reset mid-burst or mid-run drops everything immediately; no pulse is issued on release.

## Timing
- `cpuEn` is registered: high exactly one cycle, the cycle after the qualifying event (`tick` or `stepReq`).
- **Run latency:** state enters RUN at cycle t, `divCnt`=0 at t. The first `tick` is at t+2^DIV_WIDTH−1 and the first `cpuEn` at t+2^DIV_WIDTH. After that the period is exactly 2^DIV_WIDTH cycles.
- **Button latency:** a clean press reaches `btnStable` 2+DEBOUNCE_CYCLES cycles after the edge, `stepReq` on the same cycle, `cpuEn` one cycle later.
- A glitch shorter than DEBOUNCE_CYCLES produces no `stepReq`.
- **Burst of N:** exactly N `cpuEn` pulses, spaced 2^DIV_WIDTH cycles apart. `busy` falls on the cycle the Nth pulse is high.
- Mode changes take effect on the next clock edge. No pulse is ever issued while `modeSel`=00.

## Test plan
Bench uses DIV_WIDTH=3, DEBOUNCE_CYCLES=4, BURST_WIDTH=4.
- **Reset:** assert `resetN`=0 mid-run → all outputs 0 within the same cycle; after release, `stepCount`=0 and no `cpuEn` with `modeSel`=00.
- **Run:** `modeSel`=01 for 40 cycles → `cpuEn` at cycles 8, 16, 24, 32, 40 after entry, `stepCount`=5, `cpuClock` toggles every 4 cycles; switch to 00 → `busy`=0 next cycle, no further pulses.
- **Single step:**
  - `modeSel`=10, press held 10 cycles → exactly one `cpuEn`, 7 cycles after the press edge.
  - A 2-cycle glitch → no pulse.
- **Burst:**
  - `modeSel`=11, `burstCount`=3, press → exactly 3 pulses 8 cycles apart, `busy` low after the third, `stepCount`=3.
  - A second press during the burst is ignored.
  - `burstCount`=0 → no pulse.
- **Burst abort:** `burstCount`=5, change `modeSel` to 00 after the second pulse → no more pulses, `stepCount`=2, state IDLE.
- **Wrap:** issue 65537 pulses in run mode → `stepCount`=1.
